// File: rtl/reg_restore_bram.sv
// reg_restore_bram: reloads the GPR file from a snapshot held in BRAM.
// A rising edge on rd_en_i reads GPR_NUM consecutive words starting at
// BASE_ADDR. Each word is written into the matching GPR through the register
// file's write port. r0 is hard zero, so its word is read but never written.
module reg_restore_bram #(
  parameter int          GPR_NUM   = 32,
  parameter int          GPR_ADR   = 5,
  parameter int          GPR_BIT   = 32,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en_i,
  output logic               ram_clk,
  output logic               ram_rst,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [31:0]        ram_addr,
  output logic [GPR_BIT-1:0] ram_wr_data,
  input  logic [GPR_BIT-1:0] ram_rd_data,
  output logic               gpr_we,
  output logic [GPR_ADR-1:0] gpr_addr,
  output logic [GPR_BIT-1:0] gpr_wd,
  output logic               busy,
  output logic               done
);

  // One extra bit so the counter can hold GPR_NUM and never wraps inside a restore
  localparam int CNT_W = GPR_ADR + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_en_q, rd_en_d;
  logic               start;

  logic [RD_LAT-1:0]  pipe_vld_q, pipe_vld_d;
  logic [GPR_ADR-1:0] pipe_idx_q [RD_LAT];
  logic [GPR_ADR-1:0] pipe_idx_d [RD_LAT];

  logic               gpr_we_q, gpr_we_d;
  logic [GPR_ADR-1:0] gpr_addr_q, gpr_addr_d;
  logic [GPR_BIT-1:0] gpr_wd_q, gpr_wd_d;

  assign rd_en_d = rd_en_i;
  assign start   = rd_en_i & ~rd_en_q;

  // Sequencer: IDLE -> ISSUE for GPR_NUM reads -> DRAIN until the last word lands -> DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == CNT_W'(GPR_NUM - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Index pipeline that travels alongside the BRAM read, plus the write-port stage
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_vld_d[0] = (state_q == S_ISSUE);
    pipe_idx_d[0] = cnt_q[GPR_ADR-1:0];
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
    gpr_we_d   = pipe_vld_q[RD_LAT-1] && (pipe_idx_q[RD_LAT-1] != '0);
    gpr_addr_d = gpr_addr_q;
    gpr_wd_d   = gpr_wd_q;
    if (gpr_we_d) begin
      gpr_addr_d = pipe_idx_q[RD_LAT-1];
      gpr_wd_d   = ram_rd_data;
    end
  end

  // State registers; reset aborts a restore at once and drops any in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_en_q    <= 1'b1;
      pipe_vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_idx_q[k] <= '0;
      end
      gpr_we_q   <= 1'b0;
      gpr_addr_q <= '0;
      gpr_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      pipe_vld_q <= pipe_vld_d;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_idx_q[k] <= pipe_idx_d[k];
      end
      gpr_we_q   <= gpr_we_d;
      gpr_addr_q <= gpr_addr_d;
      gpr_wd_q   <= gpr_wd_d;
    end
  end

  assign ram_clk     = clk;
  assign ram_rst     = rst;
  assign ram_we      = 4'b0000;
  assign ram_wr_data = '0;
  assign ram_en      = (state_q == S_ISSUE);
  assign ram_addr    = ram_en ? (BASE_ADDR + 32'({cnt_q, 2'b00})) : BASE_ADDR;

  assign gpr_we   = gpr_we_q;
  assign gpr_addr = gpr_addr_q;
  assign gpr_wd   = gpr_wd_q;

  assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

endmodule
